// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared codes for the UART calculator command path
package calc_pkg;

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_MUL = 5'd3;
  localparam logic [4:0] OP_DIV = 5'd4;

  localparam logic [3:0] DT_SIGNED   = 4'd1;
  localparam logic [3:0] DT_UNSIGNED = 4'd2;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_MUL = 2'd2;
  localparam logic [1:0] ALU_DIV = 2'd3;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_R  = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ALU,
    S_SEND_RES,
    S_SEND_ERR
  } state_t;

endpackage

// File: rtl/hex_ascii_enc.sv
// rtl/hex_ascii_enc.sv - nibble to uppercase ASCII hex digit
module hex_ascii_enc (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  assign ascii = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                  : (8'h37 + {4'h0, nibble});

endmodule

// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - command sequencer: validate, launch ALU, stream hex or error reply
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int ALU_TIMEOUT  = 255,
  parameter bit RESP_TERM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        parser_done,
  input  logic [3:0]  dtype,
  input  logic [4:0]  operator,
  input  logic [15:0] src1,
  input  logic [15:0] src2,
  output logic        alu_start,
  output logic [1:0]  alu_op,
  output logic        alu_signed,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  input  logic        alu_err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        cmd_drop
);

  localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);
  // The ALU gets ALU_TIMEOUT wait cycles; the last one is when cnt holds ALU_TIMEOUT-1.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ALU_TIMEOUT - 1);
  localparam logic [3:0] RES_LAST = RESP_TERM_EN ? 4'd9 : 4'd7;
  localparam logic [3:0] ERR_LAST = RESP_TERM_EN ? 4'd4 : 4'd2;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       idx;
  logic [31:0]      res;
  logic [4:0]       nib_lsb;
  logic [7:0]       hex_char;
  logic [1:0]       op_dec;
  logic             cmd_ok;
  logic             last;

  assign cmd_ok = (dtype == DT_SIGNED || dtype == DT_UNSIGNED) &&
                  (operator >= OP_ADD) && (operator <= OP_DIV);
  assign busy     = (state != S_IDLE);
  assign cmd_drop = parser_done && busy;
  assign nib_lsb  = 5'd28 - {idx[2:0], 2'b00};

  hex_ascii_enc u_hex (
    .nibble (res[nib_lsb +: 4]),
    .ascii  (hex_char)
  );

  always_comb begin
    op_dec = ALU_ADD;
    case (operator)
      OP_SUB:  op_dec = ALU_SUB;
      OP_MUL:  op_dec = ALU_MUL;
      OP_DIV:  op_dec = ALU_DIV;
      default: op_dec = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    alu_start = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    last      = 1'b0;
    case (state)
      S_IDLE:
        if (parser_done) state_n = cmd_ok ? S_ISSUE : S_SEND_ERR;
      S_ISSUE: begin
        alu_start = 1'b1;
        state_n   = S_WAIT_ALU;
      end
      S_WAIT_ALU:
        if (alu_done)             state_n = alu_err ? S_SEND_ERR : S_SEND_RES;
        else if (cnt == TMO_LAST) state_n = S_SEND_ERR;
      S_SEND_RES: begin
        tx_valid = 1'b1;
        if (idx < 4'd8)       tx_data = hex_char;
        else if (idx == 4'd8) tx_data = CH_CR;
        else                  tx_data = CH_LF;
        last = (idx == RES_LAST);
      end
      S_SEND_ERR: begin
        tx_valid = 1'b1;
        case (idx)
          4'd0:       tx_data = CH_E;
          4'd1, 4'd2: tx_data = CH_R;
          4'd3:       tx_data = CH_CR;
          default:    tx_data = CH_LF;
        endcase
        last = (idx == ERR_LAST);
      end
      default: state_n = S_IDLE;
    endcase
    if (tx_valid && tx_ready && last) state_n = S_IDLE;
  end

  // Byte index restarts on every state change, so each SEND state begins at byte 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op     <= ALU_ADD;
      alu_signed <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      cnt        <= '0;
      res        <= '0;
      idx        <= '0;
    end else begin
      if (state == S_IDLE && parser_done && cmd_ok) begin
        alu_op     <= op_dec;
        alu_signed <= (dtype == DT_SIGNED);
        alu_a      <= src1;
        alu_b      <= src2;
      end
      cnt <= (state == S_WAIT_ALU) ? cnt + 1'b1 : '0;
      if (state == S_WAIT_ALU && alu_done && !alu_err) res <= alu_result;
      if (state_n != state)          idx <= '0;
      else if (tx_valid && tx_ready) idx <= idx + 1'b1;
    end
  end

endmodule

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
Command sequencer for the UART calculator. It sits between the command parser and two blocks: the shared multi-cycle ALU and the UART transmitter. On each parsed command it validates the fields and launches one ALU operation. It then streams the 32-bit result back as 8 uppercase ASCII hex characters plus CR LF, or as the 5-byte error string "ERR\r\n".

Parameters:
ALU_TIMEOUT, 255, max cycles waited for alu_done after alu_start before the error response (>=2)
RESP_TERM_EN, 1, 1 = append CR LF (0x0D 0x0A) after result/error; 0 = omit

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
parser_done  in  1  1-cycle pulse: command fields valid this cycle
dtype  in  4  1 = signed, 2 = unsigned, others invalid
operator  in  5  1 add, 2 sub, 3 mul, 4 div, others invalid
src1  in  16  operand A
src2  in  16  operand B
alu_start  out  1  1-cycle launch pulse
alu_op  out  2  0 add, 1 sub, 2 mul, 3 div (held from launch until IDLE)
alu_signed  out  1  signed operation (held)
alu_a  out  16  registered copy of src1
alu_b  out  16  registered copy of src2
alu_done  in  1  1-cycle pulse: alu_result/alu_err valid
alu_result  in  32  result
alu_err  in  1  divide-by-zero / invalid, qualified by alu_done
tx_data  out  8  byte to transmit
tx_valid  out  1  byte offered
tx_ready  in  1  transmitter accepts; transfer on clk edge with tx_valid && tx_ready
busy  out  1  state != IDLE
cmd_drop  out  1  1-cycle pulse: parser_done received while busy, command discarded

Behaviour:
- Reset values: all outputs 0; state IDLE; internal registers 0. Asserting rst mid-operation aborts immediately. tx_valid drops asynchronously and no partial response resumes.
- FSM states: IDLE, ISSUE, WAIT_ALU, SEND_RES, SEND_ERR.
- IDLE:
  - On parser_done, register dtype/operator/src1/src2.
  - If dtype in {1,2} and operator in 1..4: go to ISSUE.
  - Otherwise: go to SEND_ERR. No ALU activity.
- ISSUE: alu_start = 1 for exactly one cycle (the cycle after parser_done). Timeout counter cleared. Go to WAIT_ALU.
- WAIT_ALU: counter increments each cycle.
  - alu_done with alu_err = 0: capture alu_result, go to SEND_RES.
  - alu_done with alu_err = 1: go to SEND_ERR.
  - Counter reaches ALU_TIMEOUT with no alu_done: go to SEND_ERR.
  - alu_done outside WAIT_ALU (late or spurious) is ignored.
- SEND_RES: byte index 0..9.
  - Indices 0..7 send nibbles result[31:28] down to [3:0]. Mapping: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
  - Index 8 sends 0x0D; index 9 sends 0x0A.
  - With RESP_TERM_EN = 0, the last index is 7.
- SEND_ERR: bytes 0x45 0x52 0x52, then 0x0D 0x0A if RESP_TERM_EN.
- TX handshake:
  - tx_valid rises the cycle after entering a SEND state.
  - tx_data is stable while tx_valid && !tx_ready.
  - On a transfer, the index advances and the next byte is presented the following cycle. Back-to-back, one byte/cycle when tx_ready is held high.
  - After the last transfer: tx_valid = 0, go to IDLE.
- Result arithmetic: the result is shown raw. Signed sub/mul results appear as 32-bit two's complement (e.g. 1-2 signed -> "FFFFFFFF"). No width adaptation; the ALU owns sign extension.
- parser_done in any non-IDLE state, including the final transfer cycle: command discarded, cmd_drop pulses that cycle, state unaffected.
- parser_done is accepted only in IDLE, so there is a 1-cycle minimum gap after busy falls.

Decomposition:
- Shared package calc_pkg holds:
  - Operator codes OP_ADD..OP_DIV = 1..4 and dtype codes DT_SIGNED = 1, DT_UNSIGNED = 2; the parser uses these too.
  - ALU op encoding (0..3).
  - ASCII constants CH_CR, CH_LF, CH_E, CH_R.
  - FSM state encoding.
- One sub-module, hex_ascii_enc: combinational 4-bit nibble -> 8-bit uppercase ASCII. Reusable by other TX formatters.

Test Plan:
- Unsigned add: dtype = 2, operator = 1, src1 = 0x1234, src2 = 0x0001; ALU returns 0x00001235 three cycles after alu_start; tx_ready = 1. Required response:
  - alu_start the cycle after parser_done, alu_op = 0, alu_signed = 0.
  - TX bytes 30 30 30 30 31 32 33 35 0D 0A on consecutive cycles.
  - busy low afterwards.
- Backpressure: same command with tx_ready toggling 1 cycle high / 2 cycles low -> identical byte sequence, tx_data held stable while stalled, no byte lost or duplicated.
- Divide by zero: dtype = 1, operator = 4, src2 = 0; ALU returns alu_done with alu_err = 1 -> bytes 45 52 52 0D 0A.
- Invalid fields: operator = 7 (then separately dtype = 0) -> no alu_start ever; "ERR\r\n" sent.
- Timeout: ALU never answers -> error response begins ALU_TIMEOUT+1 cycles after alu_start. A later alu_done is ignored and produces no second response.
- Overlap/reset:
  - parser_done during SEND_RES -> cmd_drop pulse, response unaltered.
  - rst asserted mid-SEND -> tx_valid and busy go 0 immediately.
  - After release, a new command runs normally.
